// File: rtl/ram_x18.sv
// ram_x18 -- ping-pong double-buffered RAM, two banks of 2^AW x 18 bits.
// The switch input picks which bank is read; the other bank takes writes.
// Reads are registered, have 1-cycle latency and no read enable.
// Optional build macro RAM_X18_PARITY_EN: each bank word carries two extra
// even-parity bits (over [8:0] and [17:9]), which are checked on every read.
// Without the macro the banks are 18 bits wide and parityErr is tied to 0.

// One storage bank. It has one synchronous write port and one asynchronous
// read port. The parent registers the read data, so the RAM has no reset and
// keeps its contents through reset and through switch toggles.
module ram_x18_bank #(
  parameter int AW = 10,
  parameter int WW = 18
) (
  input  logic          CLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WW-1:0] o_rdata
);

  logic [WW-1:0] r_mem [2**AW];

  // Write port: there is deliberately no reset, so stored words survive reset.
  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

module ram_x18 #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          WE,
  input  logic          switch,
  input  logic [AW-1:0] writeAddr,
  input  logic [17:0]   writeData,
  input  logic [AW-1:0] readAddr,
  output logic [17:0]   readData,
  output logic          parityErr
);

`ifdef RAM_X18_PARITY_EN
  localparam int WW = 20;
`else
  localparam int WW = 18;
`endif
  localparam int NUM_BANKS = 2;

  logic [NUM_BANKS-1:0]         w_bank_we;
  logic [NUM_BANKS-1:0][WW-1:0] w_bank_rd;
  logic [WW-1:0]                w_wr_word;
  logic [WW-1:0]                w_rd_word;
  logic                         w_wr_bank;
  logic [17:0]                  r_read_data;

  // The write bank is always the bank that is not being read. Read and write
  // therefore never collide, and no forwarding logic is needed.
  assign w_wr_bank = ~switch;

`ifdef RAM_X18_PARITY_EN
  // Stored word layout: {parity[17:9], parity[8:0], data}.
  assign w_wr_word = {^writeData[17:9], ^writeData[8:0], writeData};
`else
  assign w_wr_word = writeData;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    // Writes are gated by RST_N as sampled at the edge.
    assign w_bank_we[g] = RST_N & WE & (w_wr_bank == 1'(g));

    ram_x18_bank #(.AW(AW), .WW(WW)) u_bank (
      .CLK     (CLK),
      .i_we    (w_bank_we[g]),
      .i_waddr (writeAddr),
      .i_wdata (w_wr_word),
      .i_raddr (readAddr),
      .o_rdata (w_bank_rd[g])
    );
  end

  assign w_rd_word = w_bank_rd[switch];

  // Read data register: loads on every edge; reset clears it asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_read_data <= '0;
    else        r_read_data <= w_rd_word[17:0];
  end

  assign readData = r_read_data;

`ifdef RAM_X18_PARITY_EN
  logic w_perr;
  logic r_parity_err;

  // The parity is recomputed on the outgoing word. The flag is registered
  // together with the data, so it lines up with the cycle in which readData
  // is valid.
  assign w_perr = (w_rd_word[18] != ^w_rd_word[8:0]) |
                  (w_rd_word[19] != ^w_rd_word[17:9]);

  // Parity error flag register: reset clears it asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_parity_err <= 1'b0;
    else        r_parity_err <= w_perr;
  end

  assign parityErr = r_parity_err;
`else
  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_x18.sv
// Testbench for ram_x18. A reference model of the two banks, kept as plain
// arrays, predicts every read. The stimulus pushes the predictions into a
// queue. A monitor on the falling edge pops each prediction and compares it
// with the DUT outputs.
module tb_ram_x18;
  localparam int AW = 10;
  localparam int DEPTH = 2**AW;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          WE;
  logic          switch;
  logic [AW-1:0] writeAddr;
  logic [17:0]   writeData;
  logic [AW-1:0] readAddr;
  logic [17:0]   readData;
  logic          parityErr;

  ram_x18 #(.AW(AW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WE        (WE),
    .switch    (switch),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .readAddr  (readAddr),
    .readData  (readData),
    .parityErr (parityErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          known;
    logic [17:0] data;
    bit          perr;
  } exp_t;

  exp_t        sb_q[$];
  logic [17:0] m_mem [2][DEPTH];
  bit          m_vld [2][DEPTH];
  bit          m_bad [2][DEPTH];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. The inputs are applied 1 time unit after the
  // previous rising edge. At the next edge the model records the predicted
  // read result and then applies the write.
  task automatic step(input bit we, input bit sw, input int wa, input logic [17:0] wd, input int ra);
    int rb;
    int wb;
    exp_t e;
    WE = we; switch = sw; writeAddr = AW'(wa); writeData = wd; readAddr = AW'(ra);
    @(posedge CLK);
    if (RST_N) begin
      rb = sw ? 1 : 0;
      wb = 1 - rb;
      e.known = m_vld[rb][ra];
      e.data  = m_mem[rb][ra];
      e.perr  = m_bad[rb][ra];
      sb_q.push_back(e);
      if (we) begin
        m_mem[wb][wa] = wd;
        m_vld[wb][wa] = 1'b1;
        m_bad[wb][wa] = 1'b0;
      end
    end
    #1;
  endtask

  // Monitor: one prediction is retired for each read edge.
  always @(negedge CLK) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!RST_N) begin
        chk("rd_in_reset", 32'(readData), 32'h0);
      end else if (e.known) begin
        chk("readData", 32'(readData), 32'(e.data));
        chk("parityErr", 32'(parityErr), 32'(e.perr));
      end
    end
  end

  function automatic int pick_addr();
    return ($urandom_range(0, 7) == 0) ? DEPTH-1 : int'($urandom_range(0, 15));
  endfunction

  initial begin
    RST_N = 1'b0; WE = 1'b0; switch = 1'b0;
    writeAddr = '0; writeData = '0; readAddr = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) begin
        m_vld[b][a] = 1'b0; m_bad[b][a] = 1'b0; m_mem[b][a] = '0;
      end

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_readData", 32'(readData), 32'h0);
    chk("reset_parityErr", 32'(parityErr), 32'h0);
    RST_N = 1'b1;

    // Fill addresses 0..15 and the top address in both banks.
    // sw=1 writes bank0; sw=0 writes bank1.
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 16; a++) step(1'b1, b == 0, a, 18'($urandom), a);
      step(1'b1, b == 0, DEPTH-1, 18'($urandom), 0);
    end

    // First edge after a toggle uses the new roles.
    step(1'b1, 1'b1, 5, 18'h15555, 0);
    step(1'b1, 1'b0, 5, 18'h2AAAA, 5);
    step(1'b0, 1'b1, 0, 18'h0, 5);

    // Extreme addresses written into bank0, then read back from it.
    step(1'b1, 1'b1, 0, 18'h00001, 0);
    step(1'b1, 1'b1, DEPTH-1, 18'h3FFFF, 0);
    step(1'b0, 1'b0, 0, 18'h0, 0);
    step(1'b0, 1'b0, 0, 18'h0, DEPTH-1);
    step(1'b0, 1'b1, 0, 18'h0, 0);
    step(1'b0, 1'b1, 0, 18'h0, DEPTH-1);

    // Back-to-back reads.
    step(1'b0, 1'b0, 0, 18'h0, 0);
    step(1'b0, 1'b0, 0, 18'h0, 1);
    step(1'b0, 1'b0, 0, 18'h0, 2);

    // WE=0 with an active address and data must not write either bank.
    for (int i = 0; i < 10; i++) step(1'b0, i[0], 3, 18'h12345, 3);
    step(1'b0, 1'b0, 0, 18'h0, 3);
    step(1'b0, 1'b1, 0, 18'h0, 3);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), pick_addr(), 18'($urandom), pick_addr());

    // Asynchronous reset in mid-stream. Writes attempted during reset are
    // blocked, and the bank contents survive the reset.
    step(1'b1, 1'b0, 4, 18'h0ABCD, 5);
    #1 RST_N = 1'b0;
    #1;
    chk("async_rst_readData", 32'(readData), 32'h0);
    chk("async_rst_parityErr", 32'(parityErr), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, i[0], 5, 18'h3C3C3, 5);
    chk("held_rst_readData", 32'(readData), 32'h0);
    RST_N = 1'b1;
    step(1'b1, 1'b0, 6, 18'h11111, 5);
    step(1'b0, 1'b1, 0, 18'h0, 5);
    step(1'b0, 1'b0, 0, 18'h0, 6);
    step(1'b0, 1'b1, 0, 18'h0, 6);

`ifdef RAM_X18_PARITY_EN
    // Flip one stored data bit at address 7 in bank0 through the backdoor.
    step(1'b1, 1'b1, 7, 18'h2468A, 0);
    dut.g_bank[0].u_bank.r_mem[7] = dut.g_bank[0].u_bank.r_mem[7] ^ 20'h00001;
    m_mem[0][7] = m_mem[0][7] ^ 18'h00001;
    m_bad[0][7] = 1'b1;
    step(1'b0, 1'b0, 0, 18'h0, 7);
    step(1'b0, 1'b0, 0, 18'h0, 6);
    step(1'b1, 1'b1, 7, 18'h13579, 0);
    step(1'b0, 1'b0, 0, 18'h0, 7);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
